// File: rtl/psum_pkg.sv
// Shared constants and types for the partial-sum accumulation stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Holds the default widths, the processing-unit pipeline depth and the FSM state type.
package psum_pkg;

    localparam int IN_W       = 12;   // processing-unit partial-sum width
    localparam int ACC_W      = 16;   // accumulator width
    localparam int OUT_W      = 8;    // output word width

    // Depth of the processing unit's pipeline: operands in -> partial sum out.
    localparam int PU_LATENCY = 2;

    // Largest value representable in an OUT_W-bit result word.
    localparam int SAT_MAX    = (1 << OUT_W) - 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/valid_delay.sv
// Delays a 1-bit valid flag by DEPTH cycles so it lines up with a pipelined datapath.
// Latency: DEPTH cycles from in_bit to out_bit.
// Backpressure: none; shifts every cycle, the paired datapath cannot stall.
// Ports: clk/rst (sync, active-high), in_bit (flag in), out_bit (tail flop),
//        any_bit (OR of all stages: a flag is still in flight).
module valid_delay #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in_bit,
    output logic out_bit,
    output logic any_bit
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    // Shift-and-insert form works for DEPTH == 1 as well as longer lines.
    always_comb begin
        sr_d = (sr_q << 1) | DEPTH'(in_bit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign out_bit = sr_q[DEPTH-1];
    assign any_bit = |sr_q;

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates BEATS partial sums into one word, then shifts, saturates and presents it.
// Latency: last in_valid at cycle t -> out_valid at t+PU_LATENCY+1.
// Backpressure: none upstream; an unconsumed word is overwritten on completion and ovf latches.
// Ports: clk/rst (sync, active-high); in_valid + psum from the processing unit;
//        out_valid/out_ready/out_data result port; busy (window open or valid in flight);
//        ovf (sticky overwrite flag).
module psum_accumulator #(
    parameter int IN_W       = psum_pkg::IN_W,
    parameter int ACC_W      = psum_pkg::ACC_W,
    parameter int OUT_W      = psum_pkg::OUT_W,
    parameter int BEATS      = 4,
    parameter int SHIFT      = 2,
    parameter int PU_LATENCY = psum_pkg::PU_LATENCY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  psum,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             busy,
    output logic             ovf
);

    import psum_pkg::*;

    // Counter must hold the value BEATS itself (e.g. 256 needs 9 bits).
    localparam int               CNT_W    = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS);
    // Saturation limit 2^OUT_W-1 for this instance's OUT_W, widened to compare against the sum.
    localparam logic [ACC_W-1:0] SAT_LIM  = ACC_W'((1 << OUT_W) - 1);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               ovf_q, ovf_d;

    logic               beat_v;
    logic               dly_any;
    logic [ACC_W-1:0]   acc_sum;
    logic [ACC_W-1:0]   res_shr;
    logic [CNT_W-1:0]   cnt_inc;
    logic               done;

    // Aligns in_valid with the partial sum the unit produces PU_LATENCY cycles later.
    valid_delay #(
        .DEPTH (PU_LATENCY)
    ) u_valid_delay (
        .clk     (clk),
        .rst     (rst),
        .in_bit  (in_valid),
        .out_bit (beat_v),
        .any_bit (dly_any)
    );

    always_comb begin
        acc_sum = acc_q + ACC_W'(psum);
        cnt_inc = cnt_q + 1'b1;
        done    = beat_v && (cnt_inc == CNT_LAST);
        res_shr = acc_sum >> SHIFT;

        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (beat_v) begin
            if (done) begin
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                state_d = ACCUM;
                acc_d   = acc_sum;
                cnt_d   = cnt_inc;
            end
        end

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ovf_d       = ovf_q;
        if (done) begin
            // A completion always loads; if the old word is simultaneously accepted
            // nothing is lost, otherwise the overwrite is recorded.
            out_valid_d = 1'b1;
            out_data_d  = (res_shr > SAT_LIM) ? SAT_LIM[OUT_W-1:0] : res_shr[OUT_W-1:0];
            if (out_valid_q && !out_ready) begin
                ovf_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign ovf       = ovf_q;
    assign busy      = (state_q == ACCUM) | dly_any;

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator with a 2-stage processing-unit model.
// Latency: n/a.
// Backpressure: out_ready driven per test.
module tb_psum_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [11:0] psum;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        busy;
    logic        ovf;

    always #5 clk = ~clk;

    psum_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .psum      (psum),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .ovf       (ovf)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Processing-unit model: operands presented at cycle t emerge as psum at t+2.
    logic [11:0] pu_s0 = '0;
    logic [11:0] pu_s1 = '0;

    logic [7:0] sb_q[$];

    int gap_vals[4] = '{10, 20, 30, 40};
    int gap_lens[3] = '{0, 2, 5};

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    // One cycle: runs at a negedge. Checks a handshake about to occur, drives inputs,
    // then advances to the next negedge.
    task automatic step(input logic v, input logic [11:0] p);
        if (out_valid && out_ready) begin
            chk("sb_nonempty", int'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) chk("out_data", out_data, sb_q.pop_front());
        end
        psum     = pu_s1;
        pu_s1    = pu_s0;
        pu_s0    = p;
        in_valid = v;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 12'($urandom_range(0, 4095)));
    endtask

    task automatic beat(input logic [11:0] p);
        step(1'b1, p);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        idle(n);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        psum      = '0;
        @(negedge clk);
        do_reset(3);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);

        // Basic window and latency.
        out_ready = 1'b1;
        sb_q.push_back(8'd250);
        beat(12'd100); beat(12'd200); beat(12'd300); beat(12'd400);
        chk("lat_t1", out_valid, 0);
        idle(1);
        chk("lat_t2", out_valid, 0);
        idle(1);
        chk("lat_t3", out_valid, 1);
        chk("ovf_basic", ovf, 0);
        idle(2);
        chk("drained_basic", out_valid, 0);

        // Saturation.
        sb_q.push_back(8'd255);
        for (int i = 0; i < 4; i++) beat(12'd4095);
        idle(4);
        chk("busy_after_sat", busy, 0);

        // Gapped beats keep busy high until completion.
        sb_q.push_back(8'd25);
        for (int k = 0; k < 4; k++) begin
            beat(12'(gap_vals[k]));
            chk("busy_beat", busy, 1);
            if (k < 3) begin
                for (int g = 0; g < gap_lens[k]; g++) begin
                    idle(1);
                    chk("busy_gap", busy, 1);
                end
            end
        end
        idle(1);
        chk("busy_tail", busy, 1);
        idle(1);
        chk("busy_done", busy, 0);
        chk("gap_valid", out_valid, 1);
        idle(2);

        // Overwrite while stalled.
        out_ready = 1'b0;
        sb_q.push_back(8'd250);
        for (int i = 0; i < 4; i++) beat(12'd250);
        idle(2);
        chk("ovf_first_valid", out_valid, 1);
        chk("ovf_first", ovf, 0);
        sb_q.push_back(8'd100);
        for (int i = 0; i < 4; i++) beat(12'd100);
        idle(2);
        chk("ovf_second_valid", out_valid, 1);
        chk("ovf_set", ovf, 1);
        sb_q.delete(0);  // the 250 word was overwritten and is never delivered
        out_ready = 1'b1;
        idle(1);
        chk("ovf_drop_valid", out_valid, 0);
        chk("ovf_sticky", ovf, 1);
        idle(1);
        chk("ovf_sticky2", ovf, 1);
        do_reset(1);
        chk("ovf_cleared", ovf, 0);

        // Completion coincides with acceptance of the previous word.
        out_ready = 1'b0;
        sb_q.push_back(8'd40);
        for (int i = 0; i < 4; i++) beat(12'd40);
        sb_q.push_back(8'd80);
        for (int i = 0; i < 4; i++) beat(12'd80);
        idle(1);
        chk("coinc_old_valid", out_valid, 1);
        out_ready = 1'b1;
        idle(1);
        chk("coinc_valid", out_valid, 1);
        chk("coinc_ovf", ovf, 0);
        idle(1);
        chk("coinc_drained", out_valid, 0);

        // Reset mid-window with a valid in flight.
        beat(12'd40); beat(12'd40); beat(12'd40);
        do_reset(1);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", out_valid, 0);
        sb_q.push_back(8'd4);
        for (int i = 0; i < 4; i++) beat(12'd4);
        idle(1);
        chk("midrst_early", out_valid, 0);
        idle(1);
        chk("midrst_done", out_valid, 1);
        idle(2);

        chk("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Downstream stage of the 4-input processing unit: it consumes the unit's registered 12-bit partial sum, accumulates BEATS of them into one output word, then scales and saturates the result and presents it on a valid/ready port. The processing unit has no valid signal, so this block carries the operand-valid through a delay line matched to the unit's pipeline depth. The delay line aligns each flag with the partial sum it belongs to.

## Interface
- IN_W, 12, partial-sum width (processing-unit output width)
- ACC_W, 16, accumulator width; must satisfy ACC_W >= IN_W + clog2(BEATS)
- OUT_W, 8, output word width
- BEATS, 4, partial sums per output word; legal range 1..256
- SHIFT, 2, right shift applied to the final sum before saturation
- PU_LATENCY, 2, cycles from operands at the unit's inputs to its partial sum at its output
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  high in the cycle the feeder presents valid operands to the processing unit
- psum  in  IN_W  processing-unit output, unsigned
- out_ready  in  1  consumer accepts out_data this cycle
- out_valid  out  1  out_data holds an unconsumed result
- out_data  out  OUT_W  scaled, saturated result
- busy  out  1  a window is partially accumulated, or a valid is in flight in the delay line
- ovf  out  1  sticky; a result was overwritten before being consumed

## Operation
- Delay line: PU_LATENCY flops shift in_valid. Its tail, beat_v, marks the cycles in which psum is a real beat.
- FSM states:
  - IDLE: cnt=0, acc=0.
  - ACCUM: 0 < cnt < BEATS.
- Transitions on a beat_v cycle:
  - acc_next = acc + zero-extended psum; cnt_next = cnt + 1.
  - If cnt_next == BEATS: this is a completion. Load the result, clear acc and cnt, go to IDLE.
  - Otherwise go to, or stay in, ACCUM.
  - With BEATS=1, every beat is a completion from IDLE.
- Cycles with beat_v low: acc, cnt and state hold. Gaps of any length are legal.
- Result: r = (acc_next >> SHIFT). out_data = r if r <= 2^OUT_W-1, else 2^OUT_W-1. Unsigned throughout, no rounding.
- Output register, one entry:
  - Completion: load out_data, set out_valid.
  - out_valid && out_ready with no completion: clear out_valid.
  - Completion together with out_valid && out_ready: the old word is accepted, the new word is loaded, out_valid stays 1, ovf unchanged.
  - Completion with out_valid && !out_ready: the new word overwrites, out_valid stays 1, ovf set. The upstream unit cannot stall, so data loss is flagged rather than prevented.
- out_data holds its value while out_valid=0 (no forced zero).
- busy = (state == ACCUM) | (OR of the delay-line flops).

## Timing
- Reset values: out_valid=0, out_data=0, ovf=0, busy=0. The delay line, acc and cnt are cleared and the FSM is in IDLE.
- Reset mid-window discards the partial sum and every in-flight valid. The first beat after reset comes from an in_valid sampled in the cycle after rst deasserts, or later.
- Alignment: in_valid sampled at cycle t makes psum at cycle t+PU_LATENCY the corresponding beat.
- Latency: last in_valid of a window at cycle t gives out_valid=1 at t+PU_LATENCY+1, i.e. 3 cycles with the defaults.
- Throughput: one beat per cycle sustained, so one result every BEATS cycles. The consumer must accept within BEATS cycles to avoid ovf. With BEATS=1 it must keep out_ready high.
- out_ready is sampled only while out_valid=1. No combinational path runs from out_ready to any output.

## Structure
- Shared package psum_pkg holds:
  - Default widths (IN_W, ACC_W, OUT_W).
  - The FSM state enum: IDLE, ACCUM.
  - Constant SAT_MAX = 2^OUT_W-1.
  - PU_LATENCY = 2, owned alongside the processing unit's pipeline definition.
- One sub-module: valid_delay, a parameterised DEPTH-stage, 1-bit shift register with synchronous reset. It is instantiated with DEPTH=PU_LATENCY.
- The counter, accumulator, saturator and output register live in the top module.

## Test plan
- Defaults, out_ready=1, in_valid for 4 consecutive cycles with psums 100, 200, 300, 400 -> out_valid 3 cycles after the last in_valid, out_data=250 (1000>>2), ovf=0.
- 4 beats of psum=4095 -> sum 16380 >> 2 = 4095 -> out_data=255 (saturated).
- Beats 10, 20, 30, 40 separated by 0-, 2- and 5-cycle gaps -> out_data=25; busy high from the first in_valid until completion.
- out_ready=0, two full windows (1000, then 400) -> after the second: out_data=100, ovf=1. Raising out_ready -> out_valid drops next cycle, ovf stays 1.
- Completion cycle coincides with out_valid && out_ready -> old word accepted, new word loaded, out_valid stays 1, ovf=0.
- 2 beats in, then rst for 1 cycle with one in_valid still in flight, then beats 4, 4, 4, 4 -> out_data=4, and no stale beat is counted.
